simd_reg_bank: RTL and testbench

//  Parametrised SIMD register bank for the ALU pipeline: one lane-masked write port, NRD independent read channels.

---
 rtl/simd_reg_bank_pkg.sv | 16 +
 rtl/simd_reg_rdport.sv | 97 +++++++++
 rtl/simd_reg_bank.sv | 56 +++++
 tb/tb_simd_reg_bank.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_reg_bank_pkg.sv
// Shared configuration constants and types for the SIMD register bank.
package simd_reg_bank_pkg;

  localparam int TAU_VSIZE       = 8;   // lanes per vector word
  localparam int TAU_TMP_DATA_BW = 8;   // bits per lane
  localparam int TAU_SRAM_NWORD  = 20;  // words per bank, not necessarily a power of two
  localparam int TAU_SIMD_NRD    = 2;   // read channels

  typedef logic [TAU_VSIZE-1:0][TAU_TMP_DATA_BW-1:0] simd_vec_t;

  // Address width for a bank of nword entries; at least one bit
  function automatic int addr_bw(input int nword);
    return (nword > 1) ? $clog2(nword) : 1;
  endfunction

endpackage

// File: rtl/simd_reg_rdport.sv
// One read channel: private SRAM copy with lane-masked writes, rdy/ack
// request/response control, same-cycle write bypass and out-of-range zeroing.
module simd_reg_rdport
  import simd_reg_bank_pkg::*;
#(
  parameter  int VSIZE  = TAU_VSIZE,
  parameter  int TDBW   = TAU_TMP_DATA_BW,
  parameter  int NWORD  = TAU_SRAM_NWORD,
  parameter  int BYPASS = 1,
  localparam int ABW    = addr_bw(NWORD)
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_we,
  input  logic [ABW-1:0]              i_waddr,
  input  logic [VSIZE-1:0]            i_wmask,
  input  logic [VSIZE-1:0][TDBW-1:0]  i_wdata,
  input  logic                        i_rd_rdy,
  output logic                        o_rd_ack,
  input  logic [ABW-1:0]              i_raddr,
  output logic                        o_rdata_rdy,
  input  logic                        i_rdata_ack,
  output logic [VSIZE-1:0][TDBW-1:0]  o_rdata
);

  localparam logic [ABW:0] LP_NWORD = (ABW+1)'(NWORD);

  logic [VSIZE-1:0][TDBW-1:0] r_mem [NWORD];
  logic [VSIZE-1:0][TDBW-1:0] r_q;
  logic                       r_rdy;
  logic                       w_acc;
  logic                       w_rin;
  logic [VSIZE-1:0]           w_bmask;
  logic [VSIZE-1:0][TDBW-1:0] w_bdata;

  assign w_rin       = ({1'b0, i_raddr} < LP_NWORD);
  assign w_acc       = i_rd_rdy && (!r_rdy || i_rdata_ack);
  assign o_rd_ack    = w_acc;
  assign o_rdata_rdy = r_rdy;

  // Lane-masked write: each lane is its own column, unmasked lanes keep their value
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int l = 0; l < VSIZE; l++) begin
        if (i_wmask[l]) r_mem[i_waddr][l] <= i_wdata[l];
      end
    end
  end

  // Response valid and read-first SRAM output; read enable only on accept so a stalled response holds
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rdy <= 1'b0;
      r_q   <= '0;
    end else if (w_acc) begin
      r_rdy <= 1'b1;
      r_q   <= w_rin ? r_mem[i_raddr] : '0;
    end else if (i_rdata_ack) begin
      r_rdy <= 1'b0;
    end
  end

  if (BYPASS != 0) begin : g_byp
    logic [VSIZE-1:0]           r_bmask;
    logic [VSIZE-1:0][TDBW-1:0] r_bdata;

    // Capture a same-cycle write to the accepted address so the response sees it
    always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
        r_bmask <= '0;
        r_bdata <= '0;
      end else if (w_acc) begin
        if (i_we && (i_waddr == i_raddr)) begin
          r_bmask <= i_wmask;
          r_bdata <= i_wdata;
        end else begin
          r_bmask <= '0;
        end
      end
    end

    assign w_bmask = r_bmask;
    assign w_bdata = r_bdata;
  end else begin : g_nobyp
    assign w_bmask = '0;
    assign w_bdata = '0;
  end

  // Per-lane merge of forwarded write data over the SRAM output
  always_comb begin
    o_rdata = r_q;
    for (int l = 0; l < VSIZE; l++) begin
      if (w_bmask[l]) o_rdata[l] = w_bdata[l];
    end
  end

endmodule

// File: rtl/simd_reg_bank.sv
// SIMD register bank: one lane-masked write port fanned out to NRD
// replicated read channels. Out-of-range writes are dropped here.
module simd_reg_bank
  import simd_reg_bank_pkg::*;
#(
  parameter  int VSIZE  = TAU_VSIZE,
  parameter  int TDBW   = TAU_TMP_DATA_BW,
  parameter  int NWORD  = TAU_SRAM_NWORD,
  parameter  int NRD    = TAU_SIMD_NRD,
  parameter  int BYPASS = 1,
  localparam int ABW    = addr_bw(NWORD)
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 we_dval,
  input  logic [ABW-1:0]                       i_waddr,
  input  logic [VSIZE-1:0]                     i_wmask,
  input  logic [VSIZE-1:0][TDBW-1:0]           i_wdata,
  input  logic [NRD-1:0]                       rd_rdy,
  output logic [NRD-1:0]                       rd_ack,
  input  logic [NRD-1:0][ABW-1:0]              i_raddr,
  output logic [NRD-1:0]                       rdata_rdy,
  input  logic [NRD-1:0]                       rdata_ack,
  output logic [NRD-1:0][VSIZE-1:0][TDBW-1:0]  o_rdata
);

  localparam logic [ABW:0] LP_NWORD = (ABW+1)'(NWORD);

  logic w_we;

  // A dropped write must also never reach a channel's bypass path
  assign w_we = we_dval && ({1'b0, i_waddr} < LP_NWORD);

  for (genvar c = 0; c < NRD; c++) begin : g_ch
    simd_reg_rdport #(
      .VSIZE  (VSIZE),
      .TDBW   (TDBW),
      .NWORD  (NWORD),
      .BYPASS (BYPASS)
    ) u_rdport (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_we        (w_we),
      .i_waddr     (i_waddr),
      .i_wmask     (i_wmask),
      .i_wdata     (i_wdata),
      .i_rd_rdy    (rd_rdy[c]),
      .o_rd_ack    (rd_ack[c]),
      .i_raddr     (i_raddr[c]),
      .o_rdata_rdy (rdata_rdy[c]),
      .i_rdata_ack (rdata_ack[c]),
      .o_rdata     (o_rdata[c])
    );
  end

endmodule

// File: tb/tb_simd_reg_bank.sv
// Self-checking bench for simd_reg_bank: directed scenarios with literal
// expectations plus randomized traffic against a word-level bank model.
module tb_simd_reg_bank;

  localparam int VS = 8;
  localparam int BW = 8;
  localparam int NW = 20;
  localparam int NR = 2;
  localparam int AW = 5;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 we_dval = 1'b0;
  logic [AW-1:0]        i_waddr = '0;
  logic [VS-1:0]        i_wmask = '0;
  logic [63:0]          i_wdata = '0;
  logic [NR-1:0]        rd_rdy = '0;
  logic [NR-1:0]        rd_ack;
  logic [NR-1:0][AW-1:0] i_raddr = '0;
  logic [NR-1:0]        rdata_rdy;
  logic [NR-1:0]        rdata_ack = '1;
  logic [NR-1:0][63:0]  o_rdata;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: bank contents as whole words, one held response per channel
  logic [63:0]   mdl_mem [NW];
  logic [NR-1:0] m_rdy;
  logic [63:0]   m_data [NR];
  logic          m_win;

  simd_reg_bank #(
    .VSIZE (VS), .TDBW (BW), .NWORD (NW), .NRD (NR), .BYPASS (1)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .we_dval   (we_dval),
    .i_waddr   (i_waddr),
    .i_wmask   (i_wmask),
    .i_wdata   (i_wdata),
    .rd_rdy    (rd_rdy),
    .rd_ack    (rd_ack),
    .i_raddr   (i_raddr),
    .rdata_rdy (rdata_rdy),
    .rdata_ack (rdata_ack),
    .o_rdata   (o_rdata)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [7:0] m,
                                        input logic [63:0] d);
    logic [63:0] r;
    r = old;
    for (int l = 0; l < VS; l++) if (m[l]) r[l*8 +: 8] = d[l*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] rep8(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {8{b}};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  assign m_win = we_dval && (int'(i_waddr) < NW);

  // The response for an accept is the bank word as of that cycle, same-cycle write included
  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      m_rdy <= '0;
      for (int c = 0; c < NR; c++) m_data[c] <= '0;
    end else begin
      for (int c = 0; c < NR; c++) begin
        if (rd_rdy[c] && (!m_rdy[c] || rdata_ack[c])) begin
          m_rdy[c] <= 1'b1;
          if (int'(i_raddr[c]) >= NW)
            m_data[c] <= '0;
          else if (m_win && (i_waddr == i_raddr[c]))
            m_data[c] <= merge(mdl_mem[i_raddr[c]], i_wmask, i_wdata);
          else
            m_data[c] <= mdl_mem[i_raddr[c]];
        end else if (rdata_ack[c]) begin
          m_rdy[c] <= 1'b0;
        end
      end
      if (m_win) mdl_mem[i_waddr] <= merge(mdl_mem[i_waddr], i_wmask, i_wdata);
    end
  end

  // Compare DUT against the model on every cycle once out of the initial reset
  always @(negedge i_clk) begin
    if (chk_en) begin
      for (int c = 0; c < NR; c++) begin
        chk("rd_ack", 64'(rd_ack[c]), 64'(rd_rdy[c] && (!m_rdy[c] || rdata_ack[c])));
        chk("rdata_rdy", 64'(rdata_rdy[c]), 64'(m_rdy[c]));
        if (m_rdy[c]) chk("o_rdata", o_rdata[c], m_data[c]);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [63:0] d, input logic [7:0] m);
    we_dval = 1'b1;
    i_waddr = AW'(a);
    i_wdata = d;
    i_wmask = m;
    tick();
    we_dval = 1'b0;
  endtask

  initial begin
    // Reset state
    #3 i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_rdy", 64'(rdata_rdy), 64'h0);
    chk("reset_data0", o_rdata[0], 64'h0);
    chk("reset_data1", o_rdata[1], 64'h0);
    i_rst = 1'b1;
    chk_en = 1'b1;

    for (int a = 0; a < NW; a++) wr(a, {$urandom, $urandom}, 8'hFF);

    // 1: write then read next cycle, one-cycle latency
    wr(5, 64'h0706050403020100, 8'hFF);
    rd_rdy = 2'b01; i_raddr[0] = 5'd5;
    @(negedge i_clk);
    chk("t1_ack", 64'(rd_ack[0]), 64'h1);
    chk("t1_latency", 64'(rdata_rdy[0]), 64'h0);
    tick();
    rd_rdy = '0;
    @(negedge i_clk);
    chk("t1_rdy", 64'(rdata_rdy[0]), 64'h1);
    chk("t1_data", o_rdata[0], 64'h0706050403020100);
    tick();

    // 2: same-cycle masked write and read of the same address
    wr(7, 64'h1111111111111111, 8'hFF);
    we_dval = 1'b1; i_waddr = 5'd7; i_wmask = 8'h0F; i_wdata = 64'hAAAAAAAAAAAAAAAA;
    rd_rdy = 2'b10; i_raddr[1] = 5'd7;
    tick();
    we_dval = 1'b0; rd_rdy = '0;
    @(negedge i_clk);
    chk("t2_bypass", o_rdata[1], 64'h11111111AAAAAAAA);
    tick();

    // 3: stalled response holds across writes to its address
    wr(3, 64'h3333333333333333, 8'hFF);
    rd_rdy = 2'b01; i_raddr[0] = 5'd3; rdata_ack = 2'b00;
    tick();
    we_dval = 1'b1; i_waddr = 5'd3; i_wmask = 8'hFF; i_wdata = 64'h4444444444444444;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("t3_stall_ack", 64'(rd_ack[0]), 64'h0);
      chk("t3_hold_rdy", 64'(rdata_rdy[0]), 64'h1);
      chk("t3_hold_data", o_rdata[0], 64'h3333333333333333);
      tick();
    end
    we_dval = 1'b0; rdata_ack = 2'b11;
    @(negedge i_clk);
    chk("t3_reaccept", 64'(rd_ack[0]), 64'h1);
    tick();
    rd_rdy = '0;
    @(negedge i_clk);
    chk("t3_new_data", o_rdata[0], 64'h4444444444444444);
    tick();

    // 4: back-to-back reads, one response per cycle
    wr(1, rep8(1), 8'hFF);
    wr(2, rep8(2), 8'hFF);
    wr(3, rep8(3), 8'hFF);
    for (int k = 0; k < 4; k++) begin
      rd_rdy = (k < 3) ? 2'b10 : 2'b00;
      i_raddr[1] = AW'(k + 1);
      @(negedge i_clk);
      if (k < 3) chk("t4_ack", 64'(rd_ack[1]), 64'h1);
      if (k > 0) begin
        chk("t4_rdy", 64'(rdata_rdy[1]), 64'h1);
        chk("t4_data", o_rdata[1], rep8(k));
      end
      tick();
    end

    // 5: address range
    wr(19, rep8(8'h19), 8'hFF);
    wr(25, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    rd_rdy = 2'b01; i_raddr[0] = 5'd25;
    @(negedge i_clk);
    chk("t5_oor_ack", 64'(rd_ack[0]), 64'h1);
    tick();
    i_raddr[0] = 5'd19;
    @(negedge i_clk);
    chk("t5_oor_zero", o_rdata[0], 64'h0);
    tick();
    rd_rdy = '0;
    @(negedge i_clk);
    chk("t5_last_word", o_rdata[0], rep8(8'h19));
    tick();

    // 6: reset with a pending response, contents survive
    rd_rdy = 2'b01; i_raddr[0] = 5'd19; rdata_ack = 2'b00;
    tick();
    chk("t6_pending", 64'(rdata_rdy[0]), 64'h1);
    i_rst = 1'b0; rd_rdy = '0;
    #2;
    chk("t6_rst_rdy", 64'(rdata_rdy), 64'h0);
    chk("t6_rst_data", o_rdata[0], 64'h0);
    tick();
    i_rst = 1'b1; rdata_ack = 2'b11;
    rd_rdy = 2'b10; i_raddr[1] = 5'd19;
    tick();
    rd_rdy = '0;
    @(negedge i_clk);
    chk("t6_after_rst", o_rdata[1], rep8(8'h19));
    tick();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      we_dval = ($urandom_range(0, 1) == 1);
      i_waddr = AW'($urandom_range(0, 23));
      i_wmask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      i_wdata = {$urandom, $urandom};
      for (int c = 0; c < NR; c++) begin
        rd_rdy[c]    = ($urandom_range(0, 9) < 7);
        i_raddr[c]   = ($urandom_range(0, 2) == 0) ? i_waddr : AW'($urandom_range(0, 23));
        rdata_ack[c] = ($urandom_range(0, 9) < 6);
      end
      tick();
    end
    we_dval = 1'b0; rd_rdy = '0; rdata_ack = '1;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
